kernel_filter: RTL and testbench
================================

// Module: kernel_filter
// PURPOSE
//  Consumer of the line-buffer column stream. Takes one 3-pixel vertical column per valid cycle and
//  shifts it into a 3x3 window. Emits one filtered 8-bit pixel per accepted column:
//  passthrough, 3x3 Gaussian blur, or Sobel magnitude.
//  Sits between the line buffer and the disparity/threshold stages of the depth pipeline.
// PARAMETERS
//  HRES  640  active pixels per line; hcount_in range 0..HRES-1
//  VRES  360  active lines per frame; vcount_in range 0..VRES-1
// PORTS
//  clk_in          in   1       system clock; one clock, all logic on posedge
//  rst_n_in        in   1       reset, synchronous, active-low
//  line_buffer_in  in   [2:0][7:0] column: [2]=row y-1, [1]=row y (centre), [0]=row y+1
//  hcount_in       in   11      x of incoming column
//  vcount_in       in   10      y of centre row of incoming column
//  data_valid_in   in   1       column valid; no backpressure, accepted every cycle it is high
//  mode_in         in   2       0 passthrough, 1 Gaussian, 2 Sobel, 3 treated as 0
//  pixel_data_out  out  8       filtered pixel
//  hcount_out      out  11      x of output pixel
//  vcount_out      out  10      y of output pixel
//  data_valid_out  out  1       output valid
// BEHAVIOUR
//  Reset (rst_n_in low at posedge): all outputs 0, window registers 0, pipeline valids 0, latched mode 0.
//   Reset mid-frame discards in-flight data; outputs resume 3 cycles after the next valid input.
//  Window: on data_valid_in the columns shift, col0<=col1<=col2<=line_buffer_in. Hold when invalid.
//   Gaps in data_valid_in are legal and do not alter results.
//  Output centre = col1. Coordinates: hcount_out = hcount_in-1 and vcount_out = vcount_in of that input.
//   Exception: when hcount_in==0, output x=HRES-1 and y = vcount of the previously accepted column.
//   Every accepted input yields exactly one output, including the first after reset.
//  Latency: fixed 3 cycles from data_valid_in to the matching data_valid_out.
//   S1 window/coord capture; S2 sums; S3 abs/saturate/select, registered.
//  Mode: latched when data_valid_in && hcount_in==0 && vcount_in==0; constant for the whole frame.
//  Gaussian: sum = w*p with w = [1 2 1; 2 4 2; 1 2 1]; 12-bit unsigned (max 4080); out = sum>>4.
//  Sobel: Gx = (right col weights 1,2,1) - (left col weights 1,2,1); Gy = (top row) - (bottom row).
//   Gx and Gy are 11-bit signed; out = min(|Gx|+|Gy|, 255), with a 12-bit intermediate.
//  Border: in modes 1/2, out=0 when output x==0, x==HRES-1, y==0 or y==VRES-1.
//   Mode 0 always outputs the centre pixel, borders included.
// TESTING
//  1 Flat frame 100, mode 1 -> interior outputs 100; border outputs 0; 3-cycle latency.
//  2 Vertical step (x<10: 0, x>=10: 200), mode 2 -> x=9 and x=10 give 255 (Gx=800 saturated); others 0.
//  3 Mode 0, ramp pixel=x[7:0] -> out at hcount_out=k equals k; input hcount 0 gives out x=HRES-1, prior y.
//  4 Test 2 with random data_valid_in gaps -> output value/coord sequence identical to gap-free run.
//  5 mode_in 1->2 at y=100 -> frame stays Gaussian; Sobel takes effect from the next (0,0) column.
//  6 rst_n_in low 2 cycles mid-line -> outputs 0 during reset; valid out resumes 3 cycles after first valid input.

Source files
------------

// File: rtl/kernel_filter_if.sv
// Pixel/column stream bundle: payload, coordinates and a valid strobe.
// There is no backpressure, so the bundle has no ready.
//   data    payload: DataW bits (a 3-pixel column in, or one pixel out)
//   hcount  x coordinate, 11 bits
//   vcount  y coordinate, 10 bits
//   valid   payload and coordinates are meaningful this cycle
// The master drives every signal; the slave only samples them.
interface kernel_filter_if #(
  parameter int unsigned DataW = 8
);
  logic [DataW-1:0] data;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic             valid;

  modport master (output data, hcount, vcount, valid);
  modport slave  (input  data, hcount, vcount, valid);
endinterface

// File: rtl/kernel_filter.sv
// 3x3 window filter on the line-buffer column stream.
// Each accepted column shifts into a 3x3 window and produces one pixel three cycles later.
// Available filters: passthrough, Gaussian blur or Sobel magnitude.
//   clk_in    system clock, posedge
//   rst_n_in  synchronous active-low reset
//   mode_in   0 passthrough, 1 Gaussian, 2 Sobel, 3 passthrough
//             mode_in is latched on the (0,0) column.
//   col_in    column stream, data = {row y-1, row y, row y+1} (row y-1 in the top byte)
//   pix_out   filtered pixel stream
// Pipeline stages:
//   S1  window shift and coordinate capture
//   S2  weighted sums
//   S3  abs/saturate/border/select
module kernel_filter #(
  parameter int unsigned HRES = 640,
  parameter int unsigned VRES = 360
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [1:0]      mode_in,
  kernel_filter_if.slave  col_in,
  kernel_filter_if.master pix_out
);
  localparam logic [10:0] HMax = 11'(HRES - 1);
  localparam logic [9:0]  VMax = 10'(VRES - 1);

  // S1: window indexed [col][row]; col 0 is the oldest (left) column, row 2 is the top row.
  logic [2:0][2:0][7:0] win_d, win_q;
  logic        s1_valid_d, s1_valid_q;
  logic [10:0] s1_h_d, s1_h_q;
  logic [9:0]  s1_v_d, s1_v_q;
  logic [1:0]  s1_mode_d, s1_mode_q;
  logic [9:0]  prev_v_d, prev_v_q;
  logic [1:0]  mode_d, mode_q;
  // S2
  logic        s2_valid_d, s2_valid_q;
  logic [10:0] s2_h_d, s2_h_q;
  logic [9:0]  s2_v_d, s2_v_q;
  logic [1:0]  s2_mode_d, s2_mode_q;
  logic [7:0]  s2_center_d, s2_center_q;
  logic [11:0] s2_gsum_d, s2_gsum_q;
  logic [10:0] s2_gx_d, s2_gx_q;
  logic [10:0] s2_gy_d, s2_gy_q;
  // S3
  logic        out_valid_d, out_valid_q;
  logic [10:0] out_h_d, out_h_q;
  logic [9:0]  out_v_d, out_v_q;
  logic [7:0]  out_pix_d, out_pix_q;

  logic [2:0][7:0] col_data;
  logic            frame_start;
  logic [9:0]      lsum, csum, rsum, tsum, bsum;
  logic [10:0]     abs_gx, abs_gy;
  logic [11:0]     mag;
  logic            border;

  assign col_data = col_in.data;

  // Computes a + 2b + c without overflow.
  function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
  endfunction

  always_comb begin
    win_d      = win_q;
    s1_valid_d = 1'b0;
    s1_h_d     = s1_h_q;
    s1_v_d     = s1_v_q;
    s1_mode_d  = s1_mode_q;
    prev_v_d   = prev_v_q;
    mode_d     = mode_q;

    frame_start = col_in.valid && (col_in.hcount == '0) && (col_in.vcount == '0);

    if (col_in.valid) begin
      win_d      = {col_data, win_q[2], win_q[1]};
      s1_valid_d = 1'b1;
      mode_d     = frame_start ? mode_in : mode_q;
      s1_mode_d  = frame_start ? mode_in : mode_q;
      // Column x=0 completes the last window of the previous line.
      if (col_in.hcount == '0) begin
        s1_h_d = HMax;
        s1_v_d = prev_v_q;
      end else begin
        s1_h_d = col_in.hcount - 11'd1;
        s1_v_d = col_in.vcount;
      end
      prev_v_d = col_in.vcount;
    end
  end

  always_comb begin
    lsum = wsum(win_q[0][2], win_q[0][1], win_q[0][0]);
    csum = wsum(win_q[1][2], win_q[1][1], win_q[1][0]);
    rsum = wsum(win_q[2][2], win_q[2][1], win_q[2][0]);
    tsum = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
    bsum = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);

    s2_valid_d  = s1_valid_q;
    s2_h_d      = s1_h_q;
    s2_v_d      = s1_v_q;
    s2_mode_d   = s1_mode_q;
    s2_center_d = win_q[1][1];
    s2_gsum_d   = {2'b00, lsum} + {1'b0, csum, 1'b0} + {2'b00, rsum};
    s2_gx_d     = {1'b0, rsum} - {1'b0, lsum};
    s2_gy_d     = {1'b0, tsum} - {1'b0, bsum};
  end

  always_comb begin
    abs_gx = s2_gx_q[10] ? (~s2_gx_q + 11'd1) : s2_gx_q;
    abs_gy = s2_gy_q[10] ? (~s2_gy_q + 11'd1) : s2_gy_q;
    mag    = {1'b0, abs_gx} + {1'b0, abs_gy};
    border = (s2_h_q == '0) || (s2_h_q == HMax) || (s2_v_q == '0) || (s2_v_q == VMax);

    out_valid_d = s2_valid_q;
    out_h_d     = s2_h_q;
    out_v_d     = s2_v_q;
    case (s2_mode_q)
      2'd1:    out_pix_d = border ? 8'd0 : 8'(s2_gsum_q >> 4);
      2'd2:    out_pix_d = border ? 8'd0 : ((mag > 12'd255) ? 8'd255 : mag[7:0]);
      default: out_pix_d = s2_center_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      win_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_mode_q   <= '0;
      prev_v_q    <= '0;
      mode_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_h_q      <= '0;
      s2_v_q      <= '0;
      s2_mode_q   <= '0;
      s2_center_q <= '0;
      s2_gsum_q   <= '0;
      s2_gx_q     <= '0;
      s2_gy_q     <= '0;
      out_valid_q <= 1'b0;
      out_h_q     <= '0;
      out_v_q     <= '0;
      out_pix_q   <= '0;
    end else begin
      win_q       <= win_d;
      s1_valid_q  <= s1_valid_d;
      s1_h_q      <= s1_h_d;
      s1_v_q      <= s1_v_d;
      s1_mode_q   <= s1_mode_d;
      prev_v_q    <= prev_v_d;
      mode_q      <= mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_h_q      <= s2_h_d;
      s2_v_q      <= s2_v_d;
      s2_mode_q   <= s2_mode_d;
      s2_center_q <= s2_center_d;
      s2_gsum_q   <= s2_gsum_d;
      s2_gx_q     <= s2_gx_d;
      s2_gy_q     <= s2_gy_d;
      out_valid_q <= out_valid_d;
      out_h_q     <= out_h_d;
      out_v_q     <= out_v_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign pix_out.data   = out_pix_q;
  assign pix_out.hcount = out_h_q;
  assign pix_out.vcount = out_v_q;
  assign pix_out.valid  = out_valid_q;
endmodule

// File: tb/tb_kernel_filter.sv
// Self-checking bench for kernel_filter.
// The model keeps the last three accepted columns and applies the 3x3 kernels to them directly.
module tb_kernel_filter;
  localparam int HRES = 16;
  localparam int VRES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;

  kernel_filter_if #(.DataW(24)) col_if ();
  kernel_filter_if #(.DataW(8))  pix_if ();

  kernel_filter #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .mode_in  (mode),
    .col_in   (col_if),
    .pix_out  (pix_if)
  );

  always #5 clk = ~clk;

  typedef struct {int pix; int h; int v; int due;} exp_t;
  typedef struct {int pix; int h; int v;} out_t;

  exp_t        exp_q[$];
  out_t        got[$];
  out_t        ref_q[$];
  logic [23:0] hist [3];
  int          m_prev_v, m_mode, m_hc, m_vc, m_x, m_y, m_md;
  exp_t        m_e;
  exp_t        c_e;
  bit          c_v;
  out_t        c_o;
  int          cyc = 0;
  bit          in_reset = 1'b1;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          in_cyc = 0, out_cyc = 0;
  bit          seen_in = 1'b0, seen_out = 1'b0;

  int gw [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  int kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky [3][3] = '{'{1, 2, 1}, '{0, 0, 0}, '{-1, -2, -1}};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected pixel from three columns (left to right) for output coordinate (x, y).
  function automatic int model_pix(input logic [23:0] c0, input logic [23:0] c1,
                                   input logic [23:0] c2, input int md, input int x, input int y);
    logic [23:0] cols [3];
    int p [3][3];
    int s, gx, gy;
    bit brd;
    cols[0] = c0; cols[1] = c1; cols[2] = c2;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) p[r][c] = int'(cols[c][(2 - r) * 8 +: 8]);
    brd = (x == 0) || (x == HRES - 1) || (y == 0) || (y == VRES - 1);
    if (md == 1) begin
      if (brd) return 0;
      s = 0;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) s += gw[r][c] * p[r][c];
      return s / 16;
    end
    if (md == 2) begin
      if (brd) return 0;
      gx = 0; gy = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          gx += kx[r][c] * p[r][c];
          gy += ky[r][c] * p[r][c];
        end
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (s > 255) ? 255 : s;
    end
    return p[1][1];
  endfunction

  // Input monitor and reference model: one expected output per accepted column.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_prev_v = 0;
      m_mode   = 0;
      seen_in  = 1'b0;
      seen_out = 1'b0;
    end else begin
      in_reset = 1'b0;
      if (col_if.valid) begin
        m_hc = int'(col_if.hcount);
        m_vc = int'(col_if.vcount);
        if (m_hc == 0 && m_vc == 0) m_mode = int'(mode);
        m_md = (m_mode == 3) ? 0 : m_mode;
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = col_if.data;
        if (m_hc == 0) begin
          m_x = HRES - 1;
          m_y = m_prev_v;
        end else begin
          m_x = m_hc - 1;
          m_y = m_vc;
        end
        m_prev_v = m_vc;
        m_e.pix = model_pix(hist[0], hist[1], hist[2], m_md, m_x, m_y);
        m_e.h   = m_x;
        m_e.v   = m_y;
        m_e.due = cyc + 2;
        exp_q.push_back(m_e);
        if (!seen_in) begin
          seen_in = 1'b1;
          in_cyc  = cyc;
        end
      end
    end
  end

  // Output compare, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (in_reset) begin
        check("reset_valid", int'(pix_if.valid), 0);
        check("reset_outputs", int'({pix_if.data, pix_if.hcount, pix_if.vcount}), 0);
      end else begin
        c_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (c_v) c_e = exp_q.pop_front();
        check("out_valid", int'(pix_if.valid), int'(c_v));
        if (c_v && pix_if.valid) begin
          n_checks++;
          if (int'(pix_if.data) != c_e.pix || int'(pix_if.hcount) != c_e.h ||
              int'(pix_if.vcount) != c_e.v) begin
            n_fail++;
            $display("FAIL out_data cyc %0d: got pix %0d x %0d y %0d, expected pix %0d x %0d y %0d",
                     cyc, pix_if.data, pix_if.hcount, pix_if.vcount, c_e.pix, c_e.h, c_e.v);
          end
        end
      end
      if (pix_if.valid) begin
        c_o.pix = int'(pix_if.data);
        c_o.h   = int'(pix_if.hcount);
        c_o.v   = int'(pix_if.vcount);
        got.push_back(c_o);
        if (!seen_out) begin
          seen_out = 1'b1;
          out_cyc  = cyc;
        end
      end
    end
  end

  function automatic int find(input int x, input int y);
    foreach (got[i]) if (got[i].h == x && got[i].v == y) return got[i].pix;
    return -1;
  endfunction

  function automatic logic [7:0] img(input int kind, input int x);
    case (kind)
      0:       return 8'd100;
      1:       return (x < 10) ? 8'd0 : 8'd200;
      default: return 8'(x);
    endcase
  endfunction

  // kind 3 = random column data; otherwise the image is a function of x only.
  task automatic drive_col(input int x, input int y, input int kind, input int md,
                           input int gap_max);
    int gaps;
    gaps = (gap_max > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(gap_max, 1)) : 0;
    repeat (gaps) begin
      col_if.valid  = 1'b0;
      col_if.data   = 24'($urandom);
      col_if.hcount = 11'($urandom);
      col_if.vcount = 10'($urandom);
      mode          = 2'($urandom);
      @(posedge clk); #1;
    end
    col_if.valid = 1'b1;
    if (kind == 3) col_if.data = 24'($urandom);
    else col_if.data = {img(kind, x), img(kind, x), img(kind, x)};
    col_if.hcount = 11'(x);
    col_if.vcount = 10'(y);
    mode          = 2'(md);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    col_if.valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int kind, input int ma, input int mb, input int sw_y,
                            input int gap_max);
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++) drive_col(x, y, kind, (y >= sw_y) ? mb : ma, gap_max);
  endtask

  initial begin
    col_if.valid  = 1'b0;
    col_if.data   = '0;
    col_if.hcount = '0;
    col_if.vcount = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Flat 100, Gaussian
    got.delete();
    send_frame(0, 1, 1, 99, 0);
    idle(6);
    check("t1_interior", find(5, 3), 100);
    check("t1_border_x0", find(0, 3), 0);
    check("t1_border_xmax", find(15, 2), 0);
    check("t1_border_y0", find(5, 0), 0);
    check("t1_border_ymax", find(5, 7), 0);
    check("t1_latency", out_cyc - in_cyc + 1, 3);

    // Vertical step, Sobel, no gaps
    got.delete();
    send_frame(1, 2, 2, 99, 0);
    idle(6);
    ref_q = got;
    check("t2_x9", find(9, 3), 255);
    check("t2_x10", find(10, 3), 255);
    check("t2_x8", find(8, 3), 0);
    check("t2_x11", find(11, 3), 0);

    // Same frame with random gaps must give the same output sequence
    got.delete();
    send_frame(1, 2, 2, 99, 3);
    idle(6);
    check("t4_len", got.size(), ref_q.size());
    for (int i = 0; i < got.size() && i < ref_q.size(); i++)
      check("t4_seq", got[i].pix * 1000000 + got[i].h * 1000 + got[i].v,
            ref_q[i].pix * 1000000 + ref_q[i].h * 1000 + ref_q[i].v);

    // Ramp, passthrough
    got.delete();
    send_frame(2, 0, 0, 99, 1);
    idle(6);
    check("t3_ramp", find(7, 2), 7);
    check("t3_border_pass", find(12, 0), 12);
    check("t3_wrap_x", find(15, 2), 15);

    // Mode change mid-frame is ignored until the next frame start
    got.delete();
    send_frame(1, 1, 2, 4, 0);
    idle(6);
    check("t5_gauss_top", find(9, 2), 50);
    check("t5_gauss_x10", find(10, 2), 150);
    check("t5_gauss_held", find(9, 5), 50);
    got.delete();
    send_frame(1, 2, 2, 99, 0);
    idle(6);
    check("t5_sobel_next", find(9, 5), 255);

    // Random data, random modes
    for (int f = 0; f < 3; f++) begin
      int m;
      m = int'($urandom_range(3, 0));
      send_frame(3, m, m, 99, 2);
    end
    idle(6);

    // Reset mid-line with valid held high
    for (int i = 0; i < 40; i++) drive_col(i % HRES, i / HRES, 3, 1, 1);
    rst_n         = 1'b0;
    col_if.valid  = 1'b1;
    col_if.data   = 24'($urandom);
    col_if.hcount = 11'd8;
    col_if.vcount = 10'd2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    idle(2);
    for (int i = 40; i < HRES * VRES; i++) drive_col(i % HRES, i / HRES, 3, 1, 1);
    idle(6);
    check("t6_latency", out_cyc - in_cyc + 1, 3);
    check("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
